// File: rtl/frame_grabber_if.sv
// Camera byte stream into the grabber and the frame-buffer write port out of it.
interface frame_grabber_if #(
    parameter int ADDR_BITS = 15,
    parameter int DATA_BITS = 16
);
    logic                 vsync;
    logic                 href;
    logic [7:0]           din;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;

    modport master (output vsync, href, din, input wr_en, wr_addr, wr_data);
    modport slave  (input vsync, href, din, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/frame_grabber.sv
// Camera frame grabber: packs 8-bit camera bytes into pixels and writes them
// to a frame buffer at row-aligned addresses, in single-shot or continuous mode.
module frame_grabber #(
    parameter int H_RES         = 160,
    parameter int V_RES         = 120,
    parameter int BYTES_PER_PIX = 2,
    parameter int ADDR_BITS     = 15,
    parameter int CNT_BITS      = 8
) (
    input  logic                pclk,
    input  logic                rst,
    frame_grabber_if.slave      cam,
    input  logic                start,
    input  logic                continuous,
    output logic                busy,
    output logic                frame_done,
    output logic [CNT_BITS-1:0] frame_count,
    output logic                err_line,
    output logic                err_frame
);
    localparam int DATA_BITS = 8 * BYTES_PER_PIX;
    localparam int COL_BITS  = $clog2(H_RES + 2);
    localparam int ROW_BITS  = $clog2(V_RES + 2);

    localparam logic [COL_BITS-1:0]  COL_FULL   = COL_BITS'(H_RES);
    localparam logic [COL_BITS-1:0]  COL_SAT    = COL_BITS'(H_RES + 1);
    localparam logic [ROW_BITS-1:0]  ROW_FULL   = ROW_BITS'(V_RES);
    localparam logic [ROW_BITS-1:0]  ROW_SAT    = ROW_BITS'(V_RES + 1);
    localparam logic [ADDR_BITS-1:0] LINE_STEP  = ADDR_BITS'(H_RES);
    localparam logic                 PHASE_LAST = 1'(BYTES_PER_PIX - 1);

    typedef enum logic [1:0] {IDLE, ARM, SYNC, CAPTURE} state_t;

    state_t               state, next_state;
    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row, row_after;
    logic [ADDR_BITS-1:0] line_base;
    logic                 byte_phase;
    logic [7:0]           prev_byte;
    logic [DATA_BITS-1:0] pix_word;
    logic                 href_d;
    logic                 cont_latched;
    logic                 accept, enter_sync;
    logic                 line_end, pix_final, frame_end;

    generate
        if (BYTES_PER_PIX == 2) begin : g_two_byte
            assign pix_word = {prev_byte, cam.din};
        end else begin : g_one_byte
            assign pix_word = cam.din;
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // row_after is the line count including a line ending this cycle, so a frame
    // end coinciding with an href fall sees the completed line.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        line_end   = (state == CAPTURE) && href_d && !cam.href;
        pix_final  = (state == CAPTURE) && cam.href && (byte_phase == PHASE_LAST);
        frame_end  = (state == CAPTURE) && cam.vsync;
        row_after  = row;
        if (line_end && row != ROW_SAT) row_after = row + 1'b1;
        case (state)
            IDLE:    if (start) begin
                         next_state = ARM;
                         accept     = 1'b1;
                     end
            ARM:     if (cam.vsync) next_state = SYNC;
            SYNC:    if (!cam.vsync) next_state = CAPTURE;
            CAPTURE: if (cam.vsync) next_state = cont_latched ? SYNC : IDLE;
            default: next_state = IDLE;
        endcase
        enter_sync = (next_state == SYNC) && (state != SYNC);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cam.wr_en    <= 1'b0;
            cam.wr_addr  <= '0;
            cam.wr_data  <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            err_line     <= 1'b0;
            err_frame    <= 1'b0;
            col          <= '0;
            row          <= '0;
            line_base    <= '0;
            byte_phase   <= 1'b0;
            prev_byte    <= '0;
            href_d       <= 1'b0;
            cont_latched <= 1'b0;
        end else begin
            href_d     <= cam.href;
            cam.wr_en  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= (next_state != IDLE);
            if (accept) begin
                cont_latched <= continuous;
                err_line     <= 1'b0;
                err_frame    <= 1'b0;
            end
            if (state == CAPTURE) begin
                if (cam.href) begin
                    prev_byte <= cam.din;
                    if (pix_final) begin
                        if (col < COL_FULL && row < ROW_FULL) begin
                            cam.wr_en   <= 1'b1;
                            cam.wr_addr <= line_base + ADDR_BITS'(col);
                            cam.wr_data <= pix_word;
                        end
                        if (col != COL_SAT) col <= col + 1'b1;
                        byte_phase <= 1'b0;
                    end else begin
                        byte_phase <= byte_phase + 1'b1;
                    end
                end else if (line_end) begin
                    if (col != COL_FULL || byte_phase != 1'b0) err_line <= 1'b1;
                    if (row < ROW_FULL) line_base <= line_base + LINE_STEP;
                    row        <= row_after;
                    col        <= '0;
                    byte_phase <= 1'b0;
                end
                if (frame_end) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                    if (row_after != ROW_FULL) err_frame <= 1'b1;
                end
            end
            if (enter_sync) begin
                row        <= '0;
                col        <= '0;
                line_base  <= '0;
                byte_phase <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_grabber.sv
// Self-checking bench for frame_grabber: drives camera lines and compares every
// buffer write and status flag against a line/pixel reference model.
module tb_frame_grabber;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AB = 8;
    localparam int CB = 8;
    localparam int DB = 16;

    logic          pclk = 1'b0;
    logic          rst, start, continuous;
    logic          busy, frame_done, err_line, err_frame;
    logic [CB-1:0] frame_count;

    frame_grabber_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) cam ();

    frame_grabber #(
        .H_RES(H), .V_RES(V), .BYTES_PER_PIX(2), .ADDR_BITS(AB), .CNT_BITS(CB)
    ) dut (
        .pclk(pclk), .rst(rst), .cam(cam), .start(start), .continuous(continuous),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .err_line(err_line), .err_frame(err_frame)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad = 0;
    int writes_seen = 0;
    int done_seen = 0;
    int addr7_hits = 0;
    int byte_seq = 0;
    int model_state = 0;
    int model_lines = 0;
    bit model_cont = 0;
    int exp_frames = 0;
    int exp_done = 0;
    bit exp_err_line = 0;
    bit exp_err_frame = 0;
    logic [AB+DB-1:0] exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic observe();
        logic [AB+DB-1:0] e;
        if (cam.wr_en) begin
            writes_seen++;
            if (cam.wr_addr == 8'd7) addr7_hits++;
            checkOutput("wr_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", 32'(cam.wr_addr), 32'(e[AB+DB-1:DB]));
                checkOutput("wr_data", 32'(cam.wr_data), 32'(e[DB-1:0]));
            end
        end
        if (frame_done) done_seen++;
    endtask

    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
        cam.vsync = v;
        cam.href  = h;
        cam.din   = d;
        @(posedge pclk);
        @(negedge pclk);
        observe();
    endtask

    task automatic pressStart(input bit cont, input logic h, input logic [7:0] d);
        start       = 1'b1;
        continuous  = cont;
        model_state = 1;
        model_cont  = cont;
        exp_err_line  = 0;
        exp_err_frame = 0;
        applyStimulus(1'b0, h, d);
        start = 1'b0;
    endtask

    task automatic sendLine(input int nbytes, input bit finish);
        logic [7:0] b;
        logic [7:0] hi;
        int k;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (byte_seq > 0) begin
                b = 8'(byte_seq);
                byte_seq++;
            end else begin
                b = 8'($urandom_range(0, 255));
            end
            k = i / 2;
            if (model_state == 2 && (i % 2) == 1 && k < H && model_lines < V)
                exp_q.push_back({8'(model_lines * H + k), hi, b});
            hi = b;
            applyStimulus(1'b0, 1'b1, b);
        end
        if (finish) begin
            if (model_state == 2) begin
                if (nbytes != 2 * H) exp_err_line = 1;
                model_lines++;
            end
            repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic sendVsync();
        if (model_state == 2) begin
            exp_frames++;
            exp_done++;
            if (model_lines != V) exp_err_frame = 1;
            model_state = model_cont ? 2 : 0;
        end else if (model_state == 1) begin
            model_state = 2;
        end
        model_lines = 0;
        repeat (2) applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_pending"},     32'(exp_q.size()), 32'd0);
        checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'(8'(exp_frames)));
        checkOutput({tag, "_done_pulses"}, 32'(done_seen),   32'(exp_done));
        checkOutput({tag, "_err_line"},    32'(err_line),    32'(exp_err_line));
        checkOutput({tag, "_err_frame"},   32'(err_frame),   32'(exp_err_frame));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_wr_en"},       32'(cam.wr_en),   32'd0);
        checkOutput({tag, "_wr_addr"},     32'(cam.wr_addr), 32'd0);
        checkOutput({tag, "_wr_data"},     32'(cam.wr_data), 32'd0);
        checkOutput({tag, "_busy"},        32'(busy),        32'd0);
        checkOutput({tag, "_frame_done"},  32'(frame_done),  32'd0);
        checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        checkOutput({tag, "_err_line"},    32'(err_line),    32'd0);
        checkOutput({tag, "_err_frame"},   32'(err_frame),   32'd0);
    endtask

    task automatic modelReset();
        model_state   = 0;
        model_lines   = 0;
        exp_frames    = 0;
        exp_err_line  = 0;
        exp_err_frame = 0;
        exp_q.delete();
    endtask

    initial begin
        int snap;
        int nl;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        cam.vsync = 1'b0;
        cam.href = 1'b0;
        cam.din = 8'h00;
        @(negedge pclk);
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
        checkReset("reset");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] single-shot frame with ramp bytes");
        pressStart(1'b0, 1'b0, 8'h00);
        continuous = 1'b1;
        sendVsync();
        byte_seq = 1;
        repeat (V) sendLine(2 * H, 1'b1);
        byte_seq = 0;
        sendVsync();
        checkFrame("t1");
        checkOutput("t1_writes", 32'(writes_seen), 32'd12);
        checkOutput("t1_last_data", 32'(cam.wr_data), 32'h1718);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        continuous = 1'b0;

        $display("[TB] start mid-line, capture waits for vsync");
        sendLine(3, 1'b0);
        pressStart(1'b0, 1'b1, 8'h55);
        sendLine(4, 1'b1);
        sendLine(6, 1'b1);
        checkOutput("t2_armed_busy", 32'(busy), 32'd1);
        sendVsync();
        repeat (V) sendLine(2 * H, 1'b1);
        sendVsync();
        checkFrame("t2");

        $display("[TB] short line");
        snap = addr7_hits;
        pressStart(1'b0, 1'b0, 8'h00);
        sendVsync();
        sendLine(2 * H, 1'b1);
        sendLine(2 * H - 2, 1'b1);
        sendLine(2 * H, 1'b1);
        sendVsync();
        checkFrame("t3");
        checkOutput("t3_addr7_writes", 32'(addr7_hits - snap), 32'd0);

        $display("[TB] long line");
        pressStart(1'b0, 1'b0, 8'h00);
        sendVsync();
        sendLine(2 * H + 2, 1'b1);
        sendLine(2 * H, 1'b1);
        sendLine(2 * H, 1'b1);
        sendVsync();
        checkFrame("t4");

        $display("[TB] continuous capture over three frames");
        snap = done_seen;
        pressStart(1'b1, 1'b0, 8'h00);
        continuous = 1'b0;
        sendVsync();
        repeat (3) begin
            repeat (V) sendLine(2 * H, 1'b1);
            sendVsync();
        end
        checkFrame("t5");
        checkOutput("t5_done_delta", 32'(done_seen - snap), 32'd3);
        checkOutput("t5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        modelReset();
        checkReset("t5_reset");

        $display("[TB] short frame");
        pressStart(1'b0, 1'b0, 8'h00);
        sendVsync();
        repeat (V - 1) sendLine(2 * H, 1'b1);
        sendVsync();
        checkFrame("t6");

        $display("[TB] random line lengths");
        pressStart(1'b0, 1'b0, 8'h00);
        sendVsync();
        nl = $urandom_range(V - 1, V + 1);
        for (int r = 0; r < nl; r++) sendLine($urandom_range(2 * H - 3, 2 * H + 3), 1'b1);
        sendVsync();
        checkFrame("t7");

        $display("[TB] reset mid-line");
        pressStart(1'b0, 1'b0, 8'h00);
        sendVsync();
        sendLine(3, 1'b0);
        snap = done_seen;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t8_busy", 32'(busy), 32'd0);
        checkOutput("t8_wr_en", 32'(cam.wr_en), 32'd0);
        checkOutput("t8_frame_count", 32'(frame_count), 32'd0);
        checkOutput("t8_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        modelReset();
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t8_no_done", 32'(done_seen - snap), 32'd0);
        checkOutput("t8_pending", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
